// File: rtl/contador_modn.sv
// Modulo-N up/down counter with parallel load, updated on the falling edge of NEclk.
// Define CONTADOR_SATURATE_EN to hold at the limits instead of wrapping.
module contador_modn #(
    parameter int unsigned     BITS    = 8,
    parameter longint unsigned MODULUS = 256
) (
    input  logic            NEclk,
    input  logic            Reset,
    input  logic            Enable,
    input  logic            Up,
    input  logic            Load,
    input  logic [BITS-1:0] LoadValue,
    output logic [BITS-1:0] count,
    output logic            Carry
);

    localparam longint unsigned SPAN = 64'(1) << BITS;
    localparam bit              FULL = (MODULUS == SPAN);
    localparam logic [BITS-1:0] TOP  = BITS'(MODULUS - 64'(1));

    logic [BITS-1:0] count_d;
    logic            carry_d;
    logic [BITS-1:0] load_val;
    logic [BITS-1:0] inc_val;
    logic [BITS-1:0] dec_val;
    logic            at_top;
    logic            at_zero;

    assign at_top  = (count == TOP);
    assign at_zero = (count == '0);

    // Out-of-range load values clamp to the last legal state.
    assign load_val = (64'(LoadValue) < MODULUS) ? LoadValue : TOP;

    // Full-range modulus wraps naturally in binary arithmetic.
    generate
        if (FULL) begin : g_full
            assign inc_val = count + BITS'(1);
            assign dec_val = count - BITS'(1);
        end else begin : g_part
            assign inc_val = at_top  ? '0  : count + BITS'(1);
            assign dec_val = at_zero ? TOP : count - BITS'(1);
        end
    endgenerate

    // Next-state: Load > Enable > hold; Carry flags a terminal step only.
    always_comb begin
        count_d = count;
        carry_d = 1'b0;
        if (Load) begin
            count_d = load_val;
        end else if (Enable) begin
            if (Up) begin
                carry_d = at_top;
`ifdef CONTADOR_SATURATE_EN
                count_d = at_top ? TOP : inc_val;
`else
                count_d = inc_val;
`endif
            end else begin
                carry_d = at_zero;
`ifdef CONTADOR_SATURATE_EN
                count_d = at_zero ? '0 : dec_val;
`else
                count_d = dec_val;
`endif
            end
        end
    end

    always_ff @(negedge NEclk) begin
        if (Reset) begin
            count <= '0;
            Carry <= 1'b0;
        end else begin
            count <= count_d;
            Carry <= carry_d;
        end
    end

endmodule
